mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 24: memory word address width.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 16: memory word width.
REQ-003 The block SHALL have parameter TIMEOUT_CYCLES, default 1024: read watchdog limit (used only with MEM_ARB_TIMEOUT_EN).
REQ-004 The block SHALL have the following ports, as name, direction, width and meaning:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- cpu_enable  in  1  CPU ports eligible when high.
- p_req  in  3  per-port request level; port 0 = init loader, 1 = CPU data, 2 = CPU fetch.
- p_we  in  3  per-port op; 1 = write, 0 = read.
- p_addr  in  3*ADDR_WIDTH  per-port address; port i at bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- p_wdata  in  3*DATA_WIDTH  per-port write data, packed the same way.
- p_ack  out  3  one-cycle pulse: request accepted by memory.
- p_cplt  out  3  one-cycle pulse: read data valid on p_rdata.
- p_rdata  out  DATA_WIDTH  shared read data.
- mem_rdy, mem_cplt  in  1 each  memory ready; memory read-complete pulse.
- mem_data_out  in  DATA_WIDTH  memory read data.
- mem_w_en, mem_r_en  out  1 each  memory write and read strobes.
- mem_addr  out  ADDR_WIDTH  memory address.
- mem_data_in  out  DATA_WIDTH  memory write data.
- busy  out  1  high when state is not IDLE.
- timeout_err  out  1  sticky watchdog flag.

Function
REQ-005 Requesters SHALL hold p_req, p_we, p_addr and p_wdata stable from assertion until their p_ack pulse.
REQ-006 Eligible set SHALL be p_req masked to port 0 only while cpu_enable=0, otherwise all ports.
REQ-007 The FSM SHALL have exactly three states: IDLE, ISSUE and WAIT_RD.
REQ-008 In IDLE with any eligible request, the block SHALL grant by round-robin, searching from last_grant+1 modulo 3, and capture grant, op, address and data into registers; next state ISSUE.
REQ-009 In IDLE with no eligible request, the block SHALL remain in IDLE.
REQ-010 In ISSUE, mem_addr and mem_data_in SHALL equal the captured values.
REQ-011 In ISSUE, mem_w_en SHALL equal (captured write AND mem_rdy), combinationally, and mem_r_en SHALL equal (captured read AND mem_rdy).
REQ-012 In all states other than ISSUE, mem_w_en and mem_r_en SHALL be 0.
REQ-013 On acceptance (strobe high), the block SHALL update last_grant and register a p_ack[grant] pulse for the next cycle; next state is IDLE for a write and WAIT_RD for a read.
REQ-014 If mem_rdy=0 in ISSUE, the block SHALL stay in ISSUE indefinitely.
REQ-015 In WAIT_RD, on mem_cplt=1 the block SHALL register mem_data_out into p_rdata, pulse p_cplt[grant] the next cycle, and go to IDLE.
REQ-016 p_rdata SHALL hold its value until the next read completion.
REQ-017 mem_cplt outside WAIT_RD SHALL be ignored.
REQ-018 Latency with mem_rdy=1 SHALL be: request sampled in IDLE at cycle 0, strobe at cycle 1, p_ack at cycle 2, and for reads p_cplt one cycle after mem_cplt.
REQ-019 Deassertion of p_req after grant SHALL NOT abort the transaction; it completes and p_ack is still issued.
REQ-020 A request arriving while busy SHALL wait; no request SHALL be lost while held.
REQ-021 With three continuous requests, grants SHALL rotate 0,1,2,0 and no port SHALL wait more than 2 transactions.
REQ-022 cpu_enable falling mid-transaction SHALL NOT abort the current transaction; it affects the next arbitration only.

Reset
REQ-023 Asserting rst_n=0 SHALL asynchronously force state IDLE and last_grant=2, so port 0 wins first.
REQ-024 Reset SHALL asynchronously force p_ack=0, p_cplt=0, p_rdata=0, mem_addr=0, mem_data_in=0, busy=0 and timeout_err=0, with mem_w_en=0 and mem_r_en=0 immediately.
REQ-025 Reset mid-transaction SHALL drop the transaction with no p_ack or p_cplt issued.

Configuration
REQ-026 Macro MEM_ARB_TIMEOUT_EN, when defined, SHALL enable a WAIT_RD cycle counter, cleared on entry to WAIT_RD.
REQ-027 With MEM_ARB_TIMEOUT_EN, reaching TIMEOUT_CYCLES without mem_cplt SHALL set timeout_err (sticky until reset), pulse p_cplt[grant] with p_rdata all ones, and go to IDLE.
REQ-028 Without MEM_ARB_TIMEOUT_EN, WAIT_RD SHALL wait indefinitely, no counter logic SHALL exist, and timeout_err SHALL be tied 0.

Verification
REQ-029 Port 0 write, addr 0x000010, data 0xBEEF, mem_rdy=1 -> mem_w_en cycle 1 with mem_addr 0x000010 and mem_data_in 0xBEEF; p_ack[0] cycle 2.
REQ-030 Port 2 read, addr 0x000010, cpu_enable=1; memory returns 0xBEEF 3 cycles after strobe -> p_cplt[2] with p_rdata 0xBEEF one cycle after mem_cplt.
REQ-031 All three ports request continuously with cpu_enable=1 -> grants 0,1,2,0,1,2 after reset.
REQ-032 cpu_enable=0 with ports 1 and 2 requesting -> no strobe and no p_ack; after cpu_enable=1 -> port 1 granted first.
REQ-033 mem_rdy=0 for 5 cycles in ISSUE, then 1 -> exactly one strobe; rst_n pulsed in WAIT_RD -> no p_cplt, busy=0.
REQ-034 MEM_ARB_TIMEOUT_EN defined with TIMEOUT_CYCLES=8 and mem_cplt withheld -> p_cplt with p_rdata 0xFFFF and timeout_err=1.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Signal bundle between mem_arbiter, its three requesters and the memory.
// slave = arbiter view; master = requester/memory (environment) view.
interface mem_arbiter_if #(
  parameter int ADDR_WIDTH = 24,
  parameter int DATA_WIDTH = 16
);
  logic                    cpu_enable;
  logic [2:0]              p_req;
  logic [2:0]              p_we;
  logic [3*ADDR_WIDTH-1:0] p_addr;
  logic [3*DATA_WIDTH-1:0] p_wdata;
  logic [2:0]              p_ack;
  logic [2:0]              p_cplt;
  logic [DATA_WIDTH-1:0]   p_rdata;
  logic                    mem_rdy;
  logic                    mem_cplt;
  logic [DATA_WIDTH-1:0]   mem_data_out;
  logic                    mem_w_en;
  logic                    mem_r_en;
  logic [ADDR_WIDTH-1:0]   mem_addr;
  logic [DATA_WIDTH-1:0]   mem_data_in;
  logic                    busy;
  logic                    timeout_err;

  modport slave (
    input  cpu_enable, p_req, p_we, p_addr, p_wdata, mem_rdy, mem_cplt, mem_data_out,
    output p_ack, p_cplt, p_rdata, mem_w_en, mem_r_en, mem_addr, mem_data_in, busy, timeout_err
  );

  modport master (
    output cpu_enable, p_req, p_we, p_addr, p_wdata, mem_rdy, mem_cplt, mem_data_out,
    input  p_ack, p_cplt, p_rdata, mem_w_en, mem_r_en, mem_addr, mem_data_in, busy, timeout_err
  );
endinterface

// File: rtl/mem_arbiter.sv
// Three-port round-robin arbiter in front of a single-ported memory (loader, CPU data, CPU fetch).
// Optional read watchdog enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_arbiter #(
  parameter int ADDR_WIDTH     = 24,
  parameter int DATA_WIDTH     = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic         clk,
  input  logic         rst_n,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_WAIT_RD = 2'd2
  } state_t;

  state_t                r_state;
  logic [1:0]            r_last_grant;
  logic [1:0]            r_grant;
  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [DATA_WIDTH-1:0] r_mem_data_in;
  logic [DATA_WIDTH-1:0] r_p_rdata;
  logic [2:0]            r_p_ack;
  logic [2:0]            r_p_cplt;
  logic                  r_busy;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0]      r_wait_cnt;
  logic                  r_timeout_err;
`endif

  logic [2:0]            w_elig;
  logic                  w_any;
  logic [1:0]            w_pick;
  logic                  w_pick_we;
  logic [ADDR_WIDTH-1:0] w_pick_addr;
  logic [DATA_WIDTH-1:0] w_pick_wdata;
  logic                  w_w_en;
  logic                  w_r_en;
  logic                  w_accept;

  function automatic logic [1:0] next_port(input logic [1:0] p);
    case (p)
      2'd0:    next_port = 2'd1;
      2'd1:    next_port = 2'd2;
      default: next_port = 2'd0;
    endcase
  endfunction

  function automatic logic [2:0] port_onehot(input logic [1:0] p);
    case (p)
      2'd0:    port_onehot = 3'b001;
      2'd1:    port_onehot = 3'b010;
      2'd2:    port_onehot = 3'b100;
      default: port_onehot = 3'b000;
    endcase
  endfunction

  // Search starts one past the last winner; falls back to the last winner itself.
  function automatic logic [1:0] rr_pick(input logic [2:0] req, input logic [1:0] last);
    logic [1:0] c1;
    logic [1:0] c2;
    c1 = next_port(last);
    c2 = next_port(c1);
    if (req[c1]) begin
      rr_pick = c1;
    end else if (req[c2]) begin
      rr_pick = c2;
    end else begin
      rr_pick = next_port(c2);
    end
  endfunction

  // Eligibility mask and round-robin winner
  always_comb begin
    if (bus.cpu_enable) begin
      w_elig = bus.p_req;
    end else begin
      w_elig = {2'b00, bus.p_req[0]};
    end
    w_any  = |w_elig;
    w_pick = rr_pick(w_elig, r_last_grant);
  end

  // Operand mux for the winning port
  always_comb begin
    w_pick_we    = 1'b0;
    w_pick_addr  = {ADDR_WIDTH{1'b0}};
    w_pick_wdata = {DATA_WIDTH{1'b0}};
    case (w_pick)
      2'd0: begin
        w_pick_we    = bus.p_we[0];
        w_pick_addr  = bus.p_addr[0 +: ADDR_WIDTH];
        w_pick_wdata = bus.p_wdata[0 +: DATA_WIDTH];
      end
      2'd1: begin
        w_pick_we    = bus.p_we[1];
        w_pick_addr  = bus.p_addr[ADDR_WIDTH +: ADDR_WIDTH];
        w_pick_wdata = bus.p_wdata[DATA_WIDTH +: DATA_WIDTH];
      end
      2'd2: begin
        w_pick_we    = bus.p_we[2];
        w_pick_addr  = bus.p_addr[2*ADDR_WIDTH +: ADDR_WIDTH];
        w_pick_wdata = bus.p_wdata[2*DATA_WIDTH +: DATA_WIDTH];
      end
      default: begin
        w_pick_we    = 1'b0;
        w_pick_addr  = {ADDR_WIDTH{1'b0}};
        w_pick_wdata = {DATA_WIDTH{1'b0}};
      end
    endcase
  end

  // Strobes follow mem_rdy combinationally so acceptance happens in the same cycle
  always_comb begin
    if (r_state == ST_ISSUE) begin
      w_w_en = r_we & bus.mem_rdy;
      w_r_en = ~r_we & bus.mem_rdy;
    end else begin
      w_w_en = 1'b0;
      w_r_en = 1'b0;
    end
    w_accept = w_w_en | w_r_en;
  end

  // Arbitration FSM with its registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_last_grant  <= 2'd2;
      r_grant       <= 2'd0;
      r_we          <= 1'b0;
      r_mem_addr    <= {ADDR_WIDTH{1'b0}};
      r_mem_data_in <= {DATA_WIDTH{1'b0}};
      r_p_rdata     <= {DATA_WIDTH{1'b0}};
      r_p_ack       <= 3'b000;
      r_p_cplt      <= 3'b000;
      r_busy        <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
      r_wait_cnt    <= {CNT_W{1'b0}};
      r_timeout_err <= 1'b0;
`endif
    end else begin
      r_p_ack  <= 3'b000;
      r_p_cplt <= 3'b000;
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_grant       <= w_pick;
            r_we          <= w_pick_we;
            r_mem_addr    <= w_pick_addr;
            r_mem_data_in <= w_pick_wdata;
            r_state       <= ST_ISSUE;
            r_busy        <= 1'b1;
          end else begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end
        ST_ISSUE: begin
          if (w_accept) begin
            r_last_grant <= r_grant;
            r_p_ack      <= port_onehot(r_grant);
            if (r_we) begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_state <= ST_WAIT_RD;
              r_busy  <= 1'b1;
`ifdef MEM_ARB_TIMEOUT_EN
              r_wait_cnt <= {CNT_W{1'b0}};
`endif
            end
          end else begin
            r_state <= ST_ISSUE;
            r_busy  <= 1'b1;
          end
        end
        ST_WAIT_RD: begin
          if (bus.mem_cplt) begin
            r_p_rdata <= bus.mem_data_out;
            r_p_cplt  <= port_onehot(r_grant);
            r_state   <= ST_IDLE;
            r_busy    <= 1'b0;
          end
`ifdef MEM_ARB_TIMEOUT_EN
          else if (r_wait_cnt == CNT_LAST) begin
            // Watchdog expiry completes the read with an all-ones poison value
            r_p_rdata     <= {DATA_WIDTH{1'b1}};
            r_p_cplt      <= port_onehot(r_grant);
            r_timeout_err <= 1'b1;
            r_state       <= ST_IDLE;
            r_busy        <= 1'b0;
          end else begin
            r_wait_cnt <= r_wait_cnt + CNT_W'(1);
            r_state    <= ST_WAIT_RD;
            r_busy     <= 1'b1;
          end
`else
          else begin
            r_state <= ST_WAIT_RD;
            r_busy  <= 1'b1;
          end
`endif
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.mem_w_en    = w_w_en;
  assign bus.mem_r_en    = w_r_en;
  assign bus.mem_addr    = r_mem_addr;
  assign bus.mem_data_in = r_mem_data_in;
  assign bus.p_ack       = r_p_ack;
  assign bus.p_cplt      = r_p_cplt;
  assign bus.p_rdata     = r_p_rdata;
  assign bus.busy        = r_busy;
`ifdef MEM_ARB_TIMEOUT_EN
  assign bus.timeout_err = r_timeout_err;
`else
  assign bus.timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus randomized requesters/memory,
// all compared cycle by cycle against a transaction-level model.
module tb_mem_arbiter;
  localparam int AW = 24;
  localparam int DW = 16;
  localparam int TO = 8;

  logic clk;
  logic rst_n;

  mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks;
  int n_fail;

  logic          obs_wen, obs_ren;
  logic [AW-1:0] obs_addr;
  logic [DW-1:0] obs_din;
  logic [2:0]    obs_ack, obs_cplt;

  // Reference model: one transaction in flight at most
  logic          m_busy, m_issued, m_we, m_terr;
  int            m_port, m_last, m_wcnt;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_rdata;
  logic [2:0]    m_ack, m_cplt;
  int            mem_wait;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h at t=%0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 1'b0; m_issued = 1'b0; m_we = 1'b0; m_terr = 1'b0;
    m_port = 0; m_last = 2; m_wcnt = 0;
    m_addr = '0; m_wdata = '0; m_rdata = '0;
    m_ack = 3'b000; m_cplt = 3'b000;
  endtask

  task automatic model_edge();
    logic [2:0] elig;
    int pick;
    m_ack  = 3'b000;
    m_cplt = 3'b000;
    if (!m_busy) begin
      elig = bus.cpu_enable ? bus.p_req : {2'b00, bus.p_req[0]};
      pick = -1;
      for (int k = 1; k <= 3; k++)
        if (pick < 0 && elig[(m_last + k) % 3]) pick = (m_last + k) % 3;
      if (pick >= 0) begin
        m_port   = pick;
        m_we     = bus.p_we[pick];
        m_addr   = bus.p_addr[pick*AW +: AW];
        m_wdata  = bus.p_wdata[pick*DW +: DW];
        m_busy   = 1'b1;
        m_issued = 1'b0;
      end
    end else if (!m_issued) begin
      if (bus.mem_rdy) begin
        m_last = m_port;
        m_ack[m_port] = 1'b1;
        if (m_we) m_busy = 1'b0;
        else begin m_issued = 1'b1; m_wcnt = 0; end
      end
    end else if (bus.mem_cplt) begin
      m_rdata = bus.mem_data_out;
      m_cplt[m_port] = 1'b1;
      m_busy = 1'b0;
    end
`ifdef MEM_ARB_TIMEOUT_EN
    else begin
      m_wcnt++;
      if (m_wcnt == TO) begin
        m_rdata = '1;
        m_cplt[m_port] = 1'b1;
        m_busy = 1'b0;
        m_terr = 1'b1;
      end
    end
`endif
  endtask

  // One clock cycle: check combinational outputs, advance model, check registered outputs
  task automatic step();
    #1;
    obs_wen  = bus.mem_w_en;
    obs_ren  = bus.mem_r_en;
    obs_addr = bus.mem_addr;
    obs_din  = bus.mem_data_in;
    chk("mem_w_en", obs_wen, m_busy && !m_issued && m_we && bus.mem_rdy);
    chk("mem_r_en", obs_ren, m_busy && !m_issued && !m_we && bus.mem_rdy);
    chk("mem_addr", obs_addr, m_addr);
    chk("mem_data_in", obs_din, m_wdata);
    chk("busy_pre", bus.busy, m_busy);
    model_edge();
    @(posedge clk);
    #1;
    obs_ack  = bus.p_ack;
    obs_cplt = bus.p_cplt;
    chk("p_ack", obs_ack, m_ack);
    chk("p_cplt", obs_cplt, m_cplt);
    chk("p_rdata", bus.p_rdata, m_rdata);
    chk("busy", bus.busy, m_busy);
    chk("timeout_err", bus.timeout_err, m_terr);
  endtask

  task automatic set_req(input int p, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.p_req[p] = 1'b1;
    bus.p_we[p]  = we;
    bus.p_addr[p*AW +: AW]  = a;
    bus.p_wdata[p*DW +: DW] = d;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_w_en", bus.mem_w_en, 1'b0);
    chk("rst_r_en", bus.mem_r_en, 1'b0);
    chk("rst_ack", bus.p_ack, 3'b000);
    chk("rst_cplt", bus.p_cplt, 3'b000);
    chk("rst_rdata", bus.p_rdata, 16'h0000);
    chk("rst_addr", bus.mem_addr, 24'h000000);
    chk("rst_terr", bus.timeout_err, 1'b0);
    model_reset();
    obs_wen = 1'b0; obs_ren = 1'b0; obs_ack = 3'b000; obs_cplt = 3'b000;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic env_update();
    bus.mem_cplt = 1'b0;
    if (obs_ren) mem_wait = $urandom_range(1, 4);
    if (mem_wait > 0) begin
      mem_wait--;
      if (mem_wait == 0) begin
        bus.mem_cplt = 1'b1;
        bus.mem_data_out = DW'($urandom);
      end
    end else if ($urandom_range(0, 15) == 0) begin
      bus.mem_cplt = 1'b1;
      bus.mem_data_out = DW'($urandom);
    end
    bus.mem_rdy = ($urandom_range(0, 3) != 0);
    if ($urandom_range(0, 31) == 0) bus.cpu_enable = ~bus.cpu_enable;
    for (int p = 0; p < 3; p++) begin
      if (obs_ack[p]) bus.p_req[p] = 1'b0;
      else if (!bus.p_req[p] && $urandom_range(0, 3) == 0)
        set_req(p, 1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom));
    end
  endtask

  initial begin
    int   got[$];
    int   n_strobe;
    logic seen;
    logic [2:0] first_ack;

    n_checks = 0; n_fail = 0; mem_wait = 0;
    rst_n = 1'b0;
    bus.cpu_enable = 1'b0; bus.p_req = 3'b000; bus.p_we = 3'b000;
    bus.p_addr = '0; bus.p_wdata = '0;
    bus.mem_rdy = 1'b0; bus.mem_cplt = 1'b0; bus.mem_data_out = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    apply_reset();

    // Port 0 write: strobe in cycle 1, ack in cycle 2
    bus.mem_rdy = 1'b1; bus.cpu_enable = 1'b1;
    set_req(0, 1'b1, 24'h000010, 16'hBEEF);
    step();
    chk("wr_c0_no_strobe", obs_wen, 1'b0);
    step();
    chk("wr_c1_strobe", obs_wen, 1'b1);
    chk("wr_c1_addr", obs_addr, 24'h000010);
    chk("wr_c1_data", obs_din, 16'hBEEF);
    chk("wr_c2_ack", obs_ack, 3'b001);
    bus.p_req[0] = 1'b0;

    // Port 2 read, memory completes 3 cycles after the strobe
    set_req(2, 1'b0, 24'h000010, 16'h0000);
    step();
    step();
    chk("rd_strobe", obs_ren, 1'b1);
    chk("rd_ack", obs_ack, 3'b100);
    bus.p_req[2] = 1'b0;
    step();
    step();
    bus.mem_cplt = 1'b1; bus.mem_data_out = 16'hBEEF;
    step();
    chk("rd_cplt", obs_cplt, 3'b100);
    chk("rd_rdata", bus.p_rdata, 16'hBEEF);
    bus.mem_cplt = 1'b0; bus.mem_data_out = 16'h1234;
    step();
    chk("rd_cplt_pulse", obs_cplt, 3'b000);
    chk("rd_rdata_hold", bus.p_rdata, 16'hBEEF);

    // Stray mem_cplt while idle is ignored
    bus.mem_cplt = 1'b1; bus.mem_data_out = 16'h5555;
    step();
    chk("stray_cplt", obs_cplt, 3'b000);
    chk("stray_rdata", bus.p_rdata, 16'hBEEF);
    bus.mem_cplt = 1'b0;

    // Request withdrawn after grant still completes
    set_req(0, 1'b1, 24'h000020, 16'h1111);
    step();
    bus.p_req[0] = 1'b0;
    step();
    chk("drop_strobe", obs_wen, 1'b1);
    chk("drop_ack", obs_ack, 3'b001);

    // Continuous requests from all ports rotate 0,1,2,0,1,2 after reset
    apply_reset();
    set_req(0, 1'b1, 24'h000100, 16'h0A0A);
    set_req(1, 1'b1, 24'h000200, 16'h0B0B);
    set_req(2, 1'b1, 24'h000300, 16'h0C0C);
    for (int c = 0; c < 60 && got.size() < 6; c++) begin
      step();
      for (int p = 0; p < 3; p++) if (obs_ack[p]) got.push_back(p);
    end
    bus.p_req = 3'b000;
    chk("rr_count", got.size(), 6);
    for (int i = 0; i < got.size(); i++) chk("rr_order", got[i], i % 3);

    // CPU ports masked while cpu_enable is low
    bus.cpu_enable = 1'b0;
    set_req(1, 1'b1, 24'h000400, 16'h4444);
    set_req(2, 1'b0, 24'h000500, 16'h0000);
    seen = 1'b0;
    repeat (6) begin
      step();
      if (obs_wen || obs_ren || obs_ack != 3'b000) seen = 1'b1;
    end
    chk("dis_no_activity", seen, 1'b0);
    bus.cpu_enable = 1'b1;
    first_ack = 3'b000;
    for (int c = 0; c < 10 && first_ack == 3'b000; c++) begin
      step();
      first_ack = obs_ack;
    end
    bus.p_req = 3'b000;
    chk("en_first_grant", first_ack, 3'b010);

    // Stalled ISSUE gives exactly one strobe; reset inside WAIT_RD drops the read
    bus.mem_rdy = 1'b0;
    set_req(0, 1'b0, 24'h000030, 16'h0000);
    step();
    n_strobe = 0;
    repeat (5) begin
      step();
      n_strobe += int'(obs_wen | obs_ren);
    end
    bus.mem_rdy = 1'b1;
    step();
    n_strobe += int'(obs_wen | obs_ren);
    bus.p_req[0] = 1'b0;
    repeat (2) begin
      step();
      n_strobe += int'(obs_wen | obs_ren);
    end
    chk("stall_one_strobe", n_strobe, 1);
    chk("stall_busy_wait", bus.busy, 1'b1);
    apply_reset();
    bus.mem_cplt = 1'b1; bus.mem_data_out = 16'h7777;
    step();
    chk("rst_drop_cplt", obs_cplt, 3'b000);
    bus.mem_cplt = 1'b0;

`ifdef MEM_ARB_TIMEOUT_EN
    set_req(0, 1'b0, 24'h000040, 16'h0000);
    step();
    step();
    bus.p_req[0] = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      step();
      seen = obs_cplt[0];
    end
    chk("to_cplt", seen, 1'b1);
    chk("to_rdata", bus.p_rdata, 16'hFFFF);
    chk("to_err", bus.timeout_err, 1'b1);
`endif

    // Randomized traffic
    apply_reset();
    mem_wait = 0;
    bus.cpu_enable = 1'b1;
    repeat (3000) begin
      env_update();
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
